// File: rtl/wb_trace_buffer_pkg.sv
// Shared types, flag positions and entry packing helpers for the writeback
// retire-trace buffer.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    TIMEOUT = 2'd2
  } wb_state_e;

  // Bit positions inside the 4-bit flags field
  localparam int FLG_REG = 0;
  localparam int FLG_MRD = 1;
  localparam int FLG_MWR = 2;
  localparam int FLG_HLT = 3;

  localparam int FLAGS_W = 4;
  localparam int INST_W  = 16;

  // Scratch widths for the generic packer; the caller truncates to ENTRY_W
  localparam int FIELD_MAX = 64;
  localparam int ENTRY_MAX = 512;

  function automatic int entry_w(input int addrW, input int dataW, input int regW);
    return FLAGS_W + 2 * addrW + INST_W + regW + 2 * dataW;
  endfunction

  // Field LSB offsets, LSB field first
  function automatic int off_mem_data();
    return 0;
  endfunction
  function automatic int off_mem_addr(input int dataW);
    return dataW;
  endfunction
  function automatic int off_reg_data(input int addrW, input int dataW);
    return addrW + dataW;
  endfunction
  function automatic int off_reg_dst(input int addrW, input int dataW);
    return addrW + 2 * dataW;
  endfunction
  function automatic int off_inst(input int addrW, input int dataW, input int regW);
    return addrW + 2 * dataW + regW;
  endfunction
  function automatic int off_pc(input int addrW, input int dataW, input int regW);
    return addrW + 2 * dataW + regW + INST_W;
  endfunction
  function automatic int off_flags(input int addrW, input int dataW, input int regW);
    return 2 * addrW + 2 * dataW + regW + INST_W;
  endfunction

  function automatic logic [ENTRY_MAX-1:0] low_mask(input int w);
    return ~({ENTRY_MAX{1'b1}} << w);
  endfunction

  // Packs MSB to LSB: flags, pc, inst, reg_dst, reg_data, mem_addr, mem_data
  function automatic logic [ENTRY_MAX-1:0] pack_entry(
    input logic [3:0]           flags,
    input logic [FIELD_MAX-1:0] pc,
    input logic [FIELD_MAX-1:0] inst,
    input logic [FIELD_MAX-1:0] regDst,
    input logic [FIELD_MAX-1:0] regData,
    input logic [FIELD_MAX-1:0] memAddr,
    input logic [FIELD_MAX-1:0] memData,
    input int                   addrW,
    input int                   dataW,
    input int                   regW
  );
    logic [ENTRY_MAX-1:0] e;
    e = ENTRY_MAX'(flags);
    e = (e << addrW)  | (ENTRY_MAX'(pc)      & low_mask(addrW));
    e = (e << INST_W) | (ENTRY_MAX'(inst)    & low_mask(INST_W));
    e = (e << regW)   | (ENTRY_MAX'(regDst)  & low_mask(regW));
    e = (e << dataW)  | (ENTRY_MAX'(regData) & low_mask(dataW));
    e = (e << addrW)  | (ENTRY_MAX'(memAddr) & low_mask(addrW));
    e = (e << dataW)  | (ENTRY_MAX'(memData) & low_mask(dataW));
    return e;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Retire bus plus show-ahead read port of the trace buffer.
// Handshake: the retire bus has no back-pressure; any asserted event strobe
// is a completed retire in that cycle. On the read side an entry is consumed
// at a clock edge where rd_valid && rd_pop; rd_pop with rd_valid low is
// ignored, and rd_entry is valid whenever rd_valid is high.
interface wb_trace_buffer_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int ENTRY_W = 88
);
  logic [ADDR_W-1:0]  wb_pc;
  logic [15:0]        wb_inst;
  logic               wb_reg_write;
  logic [REG_W-1:0]   wb_reg_dst;
  logic [DATA_W-1:0]  wb_reg_data;
  logic               wb_mem_read;
  logic               wb_mem_write;
  logic [ADDR_W-1:0]  wb_mem_addr;
  logic [DATA_W-1:0]  wb_mem_wdata;
  logic [DATA_W-1:0]  wb_mem_rdata;
  logic               wb_halt;
  logic               rd_pop;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_entry;

  modport master (
    output wb_pc, wb_inst, wb_reg_write, wb_reg_dst, wb_reg_data,
           wb_mem_read, wb_mem_write, wb_mem_addr, wb_mem_wdata,
           wb_mem_rdata, wb_halt, rd_pop,
    input  rd_valid, rd_entry
  );

  modport slave (
    input  wb_pc, wb_inst, wb_reg_write, wb_reg_dst, wb_reg_data,
           wb_mem_read, wb_mem_write, wb_mem_addr, wb_mem_wdata,
           wb_mem_rdata, wb_halt, rd_pop,
    output rd_valid, rd_entry
  );
endinterface

// File: rtl/wb_trace_buffer_ring.sv
// Circular buffer with show-ahead head, occupancy count and a loss pulse.
// Storage is not reset; clr resets pointers and count only.
module trace_ring #(
  parameter int WIDTH     = 88,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             full;
  logic             doPop;
  logic             doWrite;
  logic             advHead;

  // Decide which pointers move; a pop frees the slot a full-buffer push needs
  always_comb begin
    full    = (count == (PTR_W + 1)'(DEPTH));
    doPop   = pop && (count != '0);
    drop    = push && full && !doPop;
    doWrite = push && (!drop || (OVERWRITE != 0));
    advHead = doPop || (drop && (OVERWRITE != 0));
  end

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (doWrite) tail <= tail + 1'b1;
      if (advHead) head <= head + 1'b1;
      if (doWrite && !advHead)      count <= count + 1'b1;
      else if (advHead && !doWrite) count <= count - 1'b1;
    end
  end

  // Entry storage write
  always_ff @(posedge clk) begin
    if (doWrite && !clr) mem[tail] <= wdata;
  end

  assign rdata = mem[head];

endmodule

// File: rtl/wb_trace_buffer.sv
// Retire-trace capture on the writeback stage: packs each retire event into
// a trace entry, buffers it, and keeps cycle/instruction counters plus a
// no-retire watchdog.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_W      = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 100000,
  parameter int OVERWRITE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  wb_trace_buffer_if.slave        bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [CNT_W-1:0]        dropped,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        inst_count,
  output logic                    halted,
  output logic                    timeout,
  output wb_state_e               dbg_state
);
  localparam int ENTRY_W = entry_w(ADDR_W, DATA_W, REG_W);
  // WDOG_LIMIT must be at least 2 so the idle counter has a bit
  localparam int IDLE_W  = $clog2(WDOG_LIMIT);

  wb_state_e          state;
  wb_state_e          nextState;
  logic [IDLE_W-1:0]  idleCnt;
  logic               ev;
  logic               isRun;
  logic               softClr;
  logic               ringDrop;
  logic [3:0]         flags;
  logic [DATA_W-1:0]  memData;
  logic [ENTRY_W-1:0] entry;

  assign ev      = bus.wb_reg_write | bus.wb_mem_read | bus.wb_mem_write | bus.wb_halt;
  assign isRun   = (state == RUN);
  assign softClr = rst | clr;

  assign flags[FLG_REG] = bus.wb_reg_write;
  assign flags[FLG_MRD] = bus.wb_mem_read;
  assign flags[FLG_MWR] = bus.wb_mem_write;
  assign flags[FLG_HLT] = bus.wb_halt;
  assign memData = bus.wb_mem_write ? bus.wb_mem_wdata : bus.wb_mem_rdata;
  assign entry   = ENTRY_W'(pack_entry(flags,
                                       FIELD_MAX'(bus.wb_pc),
                                       FIELD_MAX'(bus.wb_inst),
                                       FIELD_MAX'(bus.wb_reg_dst),
                                       FIELD_MAX'(bus.wb_reg_data),
                                       FIELD_MAX'(bus.wb_mem_addr),
                                       FIELD_MAX'(memData),
                                       ADDR_W, DATA_W, REG_W));

  trace_ring #(
    .WIDTH    (ENTRY_W),
    .DEPTH    (DEPTH),
    .OVERWRITE(OVERWRITE)
  ) u_ring (
    .clk  (clk),
    .clr  (softClr),
    .push (isRun && ev),
    .pop  (bus.rd_pop),
    .wdata(entry),
    .rdata(bus.rd_entry),
    .count(count),
    .drop (ringDrop)
  );

  // Next-state: halt wins over the watchdog; terminal states hold
  always_comb begin
    nextState = state;
    case (state)
      RUN: begin
        if (ev && bus.wb_halt) nextState = HALTED;
        else if (!ev && (idleCnt == IDLE_W'(WDOG_LIMIT - 1))) nextState = TIMEOUT;
      end
      default: nextState = state;
    endcase
  end

  // State register; rst and clr both return to RUN
  always_ff @(posedge clk) begin
    if (softClr) state <= RUN;
    else         state <= nextState;
  end

  // Saturating counters, watchdog and sticky overflow, frozen outside RUN
  always_ff @(posedge clk) begin
    if (softClr) begin
      cycle_count <= '0;
      inst_count  <= '0;
      dropped     <= '0;
      overflow    <= 1'b0;
      idleCnt     <= '0;
    end else if (isRun) begin
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if ((bus.wb_halt | bus.wb_reg_write | bus.wb_mem_write) && (inst_count != '1))
        inst_count <= inst_count + 1'b1;
      idleCnt <= ev ? '0 : idleCnt + 1'b1;
      if (ringDrop) begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + 1'b1;
      end
    end
  end

  assign bus.rd_valid = (count != '0);
  assign halted       = (state == HALTED);
  assign timeout      = (state == TIMEOUT);
  assign dbg_state    = state;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench: dut0 drops on full, dut1 overwrites oldest. Both see the
// same retire stimulus; pops are driven per instance.
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  localparam int EW = entry_w(16, 16, 4);

  logic clk;
  logic rst;
  logic clr;
  int   checks;
  int   failures;
  logic [EW-1:0] exp_q[$];

  wb_trace_buffer_if #(.ADDR_W(16), .DATA_W(16), .REG_W(4), .ENTRY_W(EW)) b0 ();
  wb_trace_buffer_if #(.ADDR_W(16), .DATA_W(16), .REG_W(4), .ENTRY_W(EW)) b1 ();

  logic [2:0]  cnt0, cnt1;
  logic        ovf0, ovf1, hlt0, hlt1, tmo0, tmo1;
  logic [31:0] drp0, drp1, cyc0, cyc1, ins0, ins1;
  wb_state_e   st0, st1;

  wb_trace_buffer #(.DEPTH(4), .WDOG_LIMIT(8), .OVERWRITE(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .bus(b0), .count(cnt0), .overflow(ovf0),
    .dropped(drp0), .cycle_count(cyc0), .inst_count(ins0), .halted(hlt0),
    .timeout(tmo0), .dbg_state(st0)
  );

  wb_trace_buffer #(.DEPTH(4), .WDOG_LIMIT(8), .OVERWRITE(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .bus(b1), .count(cnt1), .overflow(ovf1),
    .dropped(drp1), .cycle_count(cyc1), .inst_count(ins1), .halted(hlt1),
    .timeout(tmo1), .dbg_state(st1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ev(input logic [3:0] fl, input logic [15:0] pc, input logic [15:0] inst,
                          input logic [3:0] dst, input logic [15:0] rdat, input logic [15:0] addr,
                          input logic [15:0] wdat, input logic [15:0] mrdat);
    b0.wb_reg_write = fl[0]; b0.wb_mem_read = fl[1]; b0.wb_mem_write = fl[2]; b0.wb_halt = fl[3];
    b1.wb_reg_write = fl[0]; b1.wb_mem_read = fl[1]; b1.wb_mem_write = fl[2]; b1.wb_halt = fl[3];
    b0.wb_pc = pc; b0.wb_inst = inst; b0.wb_reg_dst = dst; b0.wb_reg_data = rdat;
    b1.wb_pc = pc; b1.wb_inst = inst; b1.wb_reg_dst = dst; b1.wb_reg_data = rdat;
    b0.wb_mem_addr = addr; b0.wb_mem_wdata = wdat; b0.wb_mem_rdata = mrdat;
    b1.wb_mem_addr = addr; b1.wb_mem_wdata = wdat; b1.wb_mem_rdata = mrdat;
  endtask

  task automatic idle_inputs();
    drive_ev(4'h0, 16'h0, 16'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    b0.rd_pop = 1'b0;
    b1.rd_pop = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_reg(input logic [15:0] data);
    drive_ev(4'h1, data, 16'h0, 4'd1, data, 16'h0, 16'h0, 16'h0);
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (b0.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %0h want 0", b0.rd_valid); end
    checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    checks++; if (cyc0 !== 32'd0 || ins0 !== 32'd0 || drp0 !== 32'd0) begin failures++; $display("FAIL reset_counters: got cyc=%0d ins=%0d drp=%0d want 0", cyc0, ins0, drp0); end
    checks++; if (ovf0 !== 1'b0 || hlt0 !== 1'b0 || tmo0 !== 1'b0 || st0 !== RUN) begin failures++; $display("FAIL reset_flags: got ovf=%0h hlt=%0h tmo=%0h st=%0d want 0/0/0/RUN", ovf0, hlt0, tmo0, st0); end
    repeat (7) step();
    checks++; if (cyc0 !== 32'd7 || tmo0 !== 1'b0) begin failures++; $display("FAIL idle7: got cyc=%0d tmo=%0h want 7/0", cyc0, tmo0); end
    checks++; if (b0.rd_valid !== 1'b0 || cnt0 !== 3'd0) begin failures++; $display("FAIL idle7_empty: got valid=%0h cnt=%0d want 0/0", b0.rd_valid, cnt0); end
    step();
    checks++; if (tmo0 !== 1'b1 || cyc0 !== 32'd8 || st0 !== TIMEOUT) begin failures++; $display("FAIL idle8_timeout: got tmo=%0h cyc=%0d st=%0d want 1/8/TIMEOUT", tmo0, cyc0, st0); end
    push_reg(16'h0042);
    idle_inputs();
    step();
    checks++; if (cyc0 !== 32'd8 || cnt0 !== 3'd0 || ins0 !== 32'd0) begin failures++; $display("FAIL timeout_frozen: got cyc=%0d cnt=%0d ins=%0d want 8/0/0", cyc0, cnt0, ins0); end
  endtask

  task automatic test_watchdog_rearm();
    do_reset();
    repeat (7) step();
    push_reg(16'h0001);
    idle_inputs();
    repeat (7) step();
    checks++; if (tmo0 !== 1'b0) begin failures++; $display("FAIL wdog_rearm_early: got tmo=%0h want 0", tmo0); end
    step();
    checks++; if (tmo0 !== 1'b1 || cyc0 !== 32'd16 || ins0 !== 32'd1) begin failures++; $display("FAIL wdog_rearm_fire: got tmo=%0h cyc=%0d ins=%0d want 1/16/1", tmo0, cyc0, ins0); end
  endtask

  task automatic test_mixed_retire();
    logic [EW-1:0] exp;
    do_reset();
    exp_q.delete();
    drive_ev(4'h1, 16'h0002, 16'h3301, 4'd3, 16'h1234, 16'h0000, 16'h0000, 16'h0000); step();
    exp_q.push_back(88'h1_0002_3301_3_1234_0000_0000);
    drive_ev(4'h2, 16'h0004, 16'h5010, 4'd5, 16'h0777, 16'h0010, 16'h0000, 16'hBEEF); step();
    exp_q.push_back(88'h2_0004_5010_5_0777_0010_BEEF);
    drive_ev(4'h4, 16'h0006, 16'h6020, 4'd0, 16'h0000, 16'h0020, 16'h00AA, 16'h1111); step();
    exp_q.push_back(88'h4_0006_6020_0_0000_0020_00AA);
    checks++; if (hlt0 !== 1'b0 || ins0 !== 32'd2) begin failures++; $display("FAIL mixed_pre_halt: got hlt=%0h ins=%0d want 0/2", hlt0, ins0); end
    drive_ev(4'h8, 16'h0008, 16'hF000, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000); step();
    exp_q.push_back(88'h8_0008_F000_0_0000_0000_0000);
    checks++; if (hlt0 !== 1'b1 || st0 !== HALTED || ins0 !== 32'd3 || cnt0 !== 3'd4) begin failures++; $display("FAIL mixed_halt: got hlt=%0h st=%0d ins=%0d cnt=%0d want 1/HALTED/3/4", hlt0, st0, ins0, cnt0); end
    push_reg(16'h0055);
    idle_inputs();
    step();
    checks++; if (cyc0 !== 32'd4 || ins0 !== 32'd3 || cnt0 !== 3'd4) begin failures++; $display("FAIL halted_frozen: got cyc=%0d ins=%0d cnt=%0d want 4/3/4", cyc0, ins0, cnt0); end
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      checks++; if (b0.rd_valid !== 1'b1 || b0.rd_entry !== exp) begin failures++; $display("FAIL mixed_pop%0d: got v=%0h e=%h want 1/%h", i, b0.rd_valid, b0.rd_entry, exp); end
      b0.rd_pop = 1'b1; step(); b0.rd_pop = 1'b0;
    end
    checks++; if (b0.rd_valid !== 1'b0 || cnt0 !== 3'd0) begin failures++; $display("FAIL mixed_drained: got v=%0h cnt=%0d want 0/0", b0.rd_valid, cnt0); end
    b0.rd_pop = 1'b1; step(); b0.rd_pop = 1'b0;
    checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL pop_empty: got cnt=%0d want 0", cnt0); end
  endtask

  task automatic test_overflow_drop();
    do_reset();
    for (int i = 1; i <= 4; i++) push_reg(16'(i));
    idle_inputs();
    checks++; if (cnt0 !== 3'd4 || ovf0 !== 1'b0) begin failures++; $display("FAIL fill4: got cnt=%0d ovf=%0h want 4/0", cnt0, ovf0); end
    for (int i = 5; i <= 6; i++) push_reg(16'(i));
    idle_inputs();
    checks++; if (cnt0 !== 3'd4 || drp0 !== 32'd2 || ovf0 !== 1'b1) begin failures++; $display("FAIL drop_stats: got cnt=%0d drp=%0d ovf=%0h want 4/2/1", cnt0, drp0, ovf0); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (b0.rd_entry[47:32] !== 16'(i)) begin failures++; $display("FAIL drop_pop%0d: got %h want %h", i, b0.rd_entry[47:32], 16'(i)); end
      b0.rd_pop = 1'b1; step(); b0.rd_pop = 1'b0;
    end
  endtask

  // Runs right after test_overflow_drop: dut1 saw the same six pushes
  task automatic test_overflow_overwrite();
    checks++; if (cnt1 !== 3'd4 || drp1 !== 32'd2 || ovf1 !== 1'b1) begin failures++; $display("FAIL ovw_stats: got cnt=%0d drp=%0d ovf=%0h want 4/2/1", cnt1, drp1, ovf1); end
    for (int i = 3; i <= 6; i++) begin
      checks++; if (b1.rd_entry[47:32] !== 16'(i)) begin failures++; $display("FAIL ovw_pop%0d: got %h want %h", i, b1.rd_entry[47:32], 16'(i)); end
      b1.rd_pop = 1'b1; step(); b1.rd_pop = 1'b0;
    end
    checks++; if (b1.rd_valid !== 1'b0) begin failures++; $display("FAIL ovw_drained: got %0h want 0", b1.rd_valid); end
  endtask

  task automatic test_back_to_back_full();
    do_reset();
    for (int i = 0; i < 4; i++) push_reg(16'h0010 + 16'(i));
    drive_ev(4'h1, 16'h0014, 16'h0, 4'd1, 16'h0014, 16'h0, 16'h0, 16'h0);
    b0.rd_pop = 1'b1;
    step();
    idle_inputs();
    checks++; if (cnt0 !== 3'd4 || ovf0 !== 1'b0 || drp0 !== 32'd0) begin failures++; $display("FAIL full_pushpop: got cnt=%0d ovf=%0h drp=%0d want 4/0/0", cnt0, ovf0, drp0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (b0.rd_entry[47:32] !== 16'h0011 + 16'(i)) begin failures++; $display("FAIL full_pop%0d: got %h want %h", i, b0.rd_entry[47:32], 16'h0011 + 16'(i)); end
      b0.rd_pop = 1'b1; step(); b0.rd_pop = 1'b0;
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 3; i++) push_reg(16'h0021 + 16'(i));
    idle_inputs();
    checks++; if (cnt0 !== 3'd3 || ins0 !== 32'd3) begin failures++; $display("FAIL clr_pre: got cnt=%0d ins=%0d want 3/3", cnt0, ins0); end
    clr = 1'b1;
    push_reg(16'h0099);
    clr = 1'b0;
    idle_inputs();
    checks++; if (cnt0 !== 3'd0 || b0.rd_valid !== 1'b0 || ins0 !== 32'd0 || cyc0 !== 32'd0 || st0 !== RUN) begin failures++; $display("FAIL clr_post: got cnt=%0d v=%0h ins=%0d cyc=%0d st=%0d want 0/0/0/0/RUN", cnt0, b0.rd_valid, ins0, cyc0, st0); end
    step();
    checks++; if (cnt0 !== 3'd0 || cyc0 !== 32'd1) begin failures++; $display("FAIL clr_nocapture: got cnt=%0d cyc=%0d want 0/1", cnt0, cyc0); end
    drive_ev(4'h8, 16'h0030, 16'hF000, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0); step();
    idle_inputs();
    clr = 1'b1; step(); clr = 1'b0;
    checks++; if (hlt0 !== 1'b0 || st0 !== RUN || cnt0 !== 3'd0) begin failures++; $display("FAIL clr_from_halt: got hlt=%0h st=%0d cnt=%0d want 0/RUN/0", hlt0, st0, cnt0); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    idle_inputs();
    test_reset();
    test_watchdog_rearm();
    test_mixed_retire();
    test_overflow_drop();
    test_overflow_overwrite();
    test_back_to_back_full();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
